// File: rtl/ines_cart_mapper.sv
// iNES cartridge: parses a streamed image into PRG/CHR arrays and serves CPU/PPU
// reads with NROM, UxROM and CNROM banking, plus 8k PRG RAM and optional CHR RAM.
module ines_cart_mapper #(
    parameter int PRG_BANKS_MAX = 8,
    parameter int CHR_BANKS_MAX = 4,
    parameter int PRG_RAM_AW    = 13
) (
    input  logic        cpu_clk,
    input  logic        rst,
    input  logic        prog,
    input  logic        prog_we,
    input  logic [7:0]  prog_di,
    output logic        load_done,
    output logic        load_err,
    output logic [7:0]  mapper_id,
    output logic        mirror_v,
    input  logic [15:0] cpu_ab,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_di,
    output logic [7:0]  cpu_do,
    input  logic [13:0] ppu_ab,
    input  logic        ppu_wr,
    input  logic [7:0]  ppu_di,
    output logic [7:0]  ppu_do
);

    localparam int PRG_BW = (PRG_BANKS_MAX > 1) ? $clog2(PRG_BANKS_MAX) : 1;
    localparam int CHR_BW = (CHR_BANKS_MAX > 1) ? $clog2(CHR_BANKS_MAX) : 1;
    localparam int PRG_AW = PRG_BW + 14;
    localparam int CHR_AW = CHR_BW + 13;
    localparam int CNT_W  = ((PRG_AW > CHR_AW) ? PRG_AW : CHR_AW) + 1;
    localparam logic [7:0] PRG_MAX8 = 8'(PRG_BANKS_MAX);
    localparam logic [7:0] CHR_MAX8 = 8'(CHR_BANKS_MAX);

    typedef enum logic [2:0] {
        IDLE, HDR, TRAIN, PRG, CHR, DONE, ERR
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic               prog_q;
    logic [7:0]         prg_banks;
    logic [7:0]         chr_banks;
    logic               trainer;
    logic [7:0]         prg_bank;
    logic [7:0]         chr_bank;

    logic [7:0] prg_rom [2**PRG_AW];
    logic [7:0] chr_mem [2**CHR_AW];
    logic [7:0] prg_ram [2**PRG_RAM_AW];

    logic               prog_rise;
    logic               prog_fall;
    logic               take;
    logic [7:0]         magic_byte;
    logic               hdr_ok;
    logic [CNT_W-1:0]   prg_last;
    logic [CNT_W-1:0]   chr_last;
    logic               chr_ram_mode;
    logic               is_uxrom;
    logic               is_cnrom;

    assign prog_rise    = prog & ~prog_q;
    assign prog_fall    = ~prog & prog_q;
    assign take         = prog & prog_we & ~prog_rise;
    assign load_done    = (state == DONE);
    assign load_err     = (state == ERR);
    assign chr_ram_mode = (chr_banks == 8'd0);
    assign is_uxrom     = (mapper_id == 8'd2);
    assign is_cnrom     = (mapper_id == 8'd3);
    assign prg_last     = (CNT_W'(prg_banks) << 14) - CNT_W'(1);
    assign chr_last     = (CNT_W'(chr_banks) << 13) - CNT_W'(1);

    always_comb begin
        magic_byte = 8'h1A;
        case (cnt[1:0])
            2'd0:    magic_byte = 8'h4E;
            2'd1:    magic_byte = 8'h45;
            2'd2:    magic_byte = 8'h53;
            default: magic_byte = 8'h1A;
        endcase
    end

    // Bank counts must be powers of two so all banking can use plain masks.
    always_comb begin
        hdr_ok = (prg_banks != 8'd0) && (prg_banks <= PRG_MAX8)
              && ((prg_banks & (prg_banks - 8'd1)) == 8'd0)
              && ((chr_banks == 8'd0)
                  || ((chr_banks <= CHR_MAX8) && ((chr_banks & (chr_banks - 8'd1)) == 8'd0)))
              && ((mapper_id == 8'd0) || (mapper_id == 8'd2) || (mapper_id == 8'd3));
    end

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            prog_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            prog_q <= prog;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (prog_rise) begin
            state_nx = HDR;
            cnt_nx   = '0;
        end else begin
            case (state)
                HDR: begin
                    if (prog_fall) begin
                        state_nx = ERR;
                    end else if (take) begin
                        cnt_nx = cnt + CNT_W'(1);
                        if ((cnt < CNT_W'(4)) && (prog_di != magic_byte)) begin
                            state_nx = ERR;
                        end else if (cnt == CNT_W'(15)) begin
                            cnt_nx = '0;
                            if (!hdr_ok)      state_nx = ERR;
                            else if (trainer) state_nx = TRAIN;
                            else              state_nx = PRG;
                        end
                    end
                end
                TRAIN: begin
                    if (prog_fall) begin
                        state_nx = ERR;
                    end else if (take) begin
                        cnt_nx = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(511)) begin
                            cnt_nx   = '0;
                            state_nx = PRG;
                        end
                    end
                end
                PRG: begin
                    if (prog_fall) begin
                        state_nx = ERR;
                    end else if (take) begin
                        cnt_nx = cnt + CNT_W'(1);
                        if (cnt == prg_last) begin
                            cnt_nx   = '0;
                            state_nx = chr_ram_mode ? DONE : CHR;
                        end
                    end
                end
                CHR: begin
                    if (prog_fall) begin
                        state_nx = ERR;
                    end else if (take) begin
                        cnt_nx = cnt + CNT_W'(1);
                        if (cnt == chr_last) begin
                            cnt_nx   = '0;
                            state_nx = DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            prg_banks <= 8'd0;
            chr_banks <= 8'd0;
            trainer   <= 1'b0;
            mirror_v  <= 1'b0;
            mapper_id <= 8'd0;
        end else if ((state == HDR) && take) begin
            case (cnt[3:0])
                4'd4: prg_banks <= prog_di;
                4'd5: chr_banks <= prog_di;
                4'd6: begin
                    mirror_v       <= prog_di[0];
                    trainer        <= prog_di[2];
                    mapper_id[3:0] <= prog_di[7:4];
                end
                4'd7: mapper_id[7:4] <= prog_di[7:4];
                default: ;
            endcase
        end
    end

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            prg_bank <= 8'd0;
            chr_bank <= 8'd0;
        end else if (load_done && cpu_wr && cpu_ab[15]) begin
            if (is_uxrom)      prg_bank <= cpu_di;
            else if (is_cnrom) chr_bank <= cpu_di;
        end
    end

    logic              prg_ram_we;
    logic              chr_load_we;
    logic              chr_we;
    logic [CHR_AW-1:0] chr_wa;
    logic [7:0]        chr_wd;

    // CHR array has one write port, shared by the loader and PPU CHR RAM writes.
    assign prg_ram_we  = load_done && cpu_wr && (cpu_ab[15:13] == 3'b011);
    assign chr_load_we = (state == CHR) && take;
    assign chr_we      = chr_load_we || (load_done && chr_ram_mode && ppu_wr && !ppu_ab[13]);
    assign chr_wa      = chr_load_we ? cnt[CHR_AW-1:0] : CHR_AW'(ppu_ab[12:0]);
    assign chr_wd      = chr_load_we ? prog_di : ppu_di;

    always_ff @(posedge cpu_clk) begin
        if ((state == PRG) && take) prg_rom[cnt[PRG_AW-1:0]] <= prog_di;
        if (prg_ram_we)             prg_ram[cpu_ab[PRG_RAM_AW-1:0]] <= cpu_di;
        if (chr_we)                 chr_mem[chr_wa] <= chr_wd;
    end

    logic [14:0]       prg_mask;
    logic [7:0]        ux_bank;
    logic [PRG_AW-1:0] prg_ra;
    logic [CHR_AW-1:0] chr_ra;

    // UxROM fixes the top half of the CPU window to the last bank.
    assign prg_mask = (prg_banks == 8'd1) ? 15'h3FFF : 15'h7FFF;
    assign ux_bank  = cpu_ab[14] ? (prg_banks - 8'd1) : (prg_bank & (prg_banks - 8'd1));
    assign prg_ra   = is_uxrom ? PRG_AW'({ux_bank, cpu_ab[13:0]})
                               : PRG_AW'(cpu_ab[14:0] & prg_mask);
    assign chr_ra   = is_cnrom ? CHR_AW'({chr_bank & (chr_banks - 8'd1), ppu_ab[12:0]})
                               : CHR_AW'(ppu_ab[12:0]);

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            cpu_do <= 8'h00;
        end else if (cpu_rd) begin
            if (!load_done)                    cpu_do <= 8'h00;
            else if (cpu_ab[15])               cpu_do <= prg_rom[prg_ra];
            else if (cpu_ab[15:13] == 3'b011)  cpu_do <= prg_ram[cpu_ab[PRG_RAM_AW-1:0]];
            else                               cpu_do <= 8'h00;
        end
    end

    always_ff @(posedge cpu_clk or negedge rst) begin
        if (!rst) begin
            ppu_do <= 8'h00;
        end else if (!load_done || ppu_ab[13]) begin
            ppu_do <= 8'h00;
        end else begin
            ppu_do <= chr_mem[chr_ra];
        end
    end

endmodule

// File: tb/tb_ines_cart_mapper.sv
// Directed bench for ines_cart_mapper: streams NROM, UxROM and CNROM images and
// exercises header errors, aborted loads, reset during load and CHR RAM.
module tb_ines_cart_mapper;

    logic        cpu_clk;
    logic        rst;
    logic        prog;
    logic        prog_we;
    logic [7:0]  prog_di;
    logic        load_done;
    logic        load_err;
    logic [7:0]  mapper_id;
    logic        mirror_v;
    logic [15:0] cpu_ab;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_di;
    logic [7:0]  cpu_do;
    logic [13:0] ppu_ab;
    logic        ppu_wr;
    logic [7:0]  ppu_di;
    logic [7:0]  ppu_do;

    int checks = 0;
    int errors = 0;

    ines_cart_mapper dut (
        .cpu_clk   (cpu_clk),
        .rst       (rst),
        .prog      (prog),
        .prog_we   (prog_we),
        .prog_di   (prog_di),
        .load_done (load_done),
        .load_err  (load_err),
        .mapper_id (mapper_id),
        .mirror_v  (mirror_v),
        .cpu_ab    (cpu_ab),
        .cpu_rd    (cpu_rd),
        .cpu_wr    (cpu_wr),
        .cpu_di    (cpu_di),
        .cpu_do    (cpu_do),
        .ppu_ab    (ppu_ab),
        .ppu_wr    (ppu_wr),
        .ppu_di    (ppu_di),
        .ppu_do    (ppu_do)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    // Image content: a few NROM vector bytes, UxROM bank numbers at each bank start.
    function automatic logic [7:0] prg_byte(input int mapper, input int o);
        logic [31:0] u;
        u = o;
        if (mapper == 0 && u == 32'h0000) return 8'hA5;
        if (mapper == 0 && u == 32'h3FFC) return 8'h00;
        if (mapper == 0 && u == 32'h3FFD) return 8'hC0;
        if (mapper == 2 && u[13:0] == 14'd0) return u[21:14];
        return u[7:0] ^ u[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] chr_byte(input int o);
        logic [31:0] u;
        u = o;
        return u[7:0] ^ {1'b0, u[14:8]} ^ 8'h3C;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        prog_we = 1'b1;
        prog_di = b;
        @(negedge cpu_clk);
    endtask

    task automatic start_load();
        prog_we = 1'b0;
        prog    = 1'b0;
        @(negedge cpu_clk);
        prog = 1'b1;
        @(negedge cpu_clk);
    endtask

    task automatic send_header(input logic [7:0] b4, input logic [7:0] b5,
                               input logic [7:0] b6, input logic [7:0] b7);
        send_byte(8'h4E); send_byte(8'h45); send_byte(8'h53); send_byte(8'h1A);
        send_byte(b4); send_byte(b5); send_byte(b6); send_byte(b7);
        for (int i = 0; i < 8; i++) send_byte(8'h00);
    endtask

    task automatic send_prg(input int mapper, input int n);
        for (int i = 0; i < n; i++) send_byte(prg_byte(mapper, i));
    endtask

    task automatic send_chr(input int n);
        for (int i = 0; i < n; i++) send_byte(chr_byte(i));
    endtask

    task automatic finish_load(input string name);
        int n;
        prog_we = 1'b0;
        n = 0;
        while (load_done !== 1'b1 && n < 16) begin
            @(negedge cpu_clk);
            n++;
        end
        checks++;
        if (load_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_load_done got %b required 1", name, load_done);
        end
        prog = 1'b0;
        @(negedge cpu_clk);
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        cpu_ab = a;
        cpu_rd = 1'b1;
        @(negedge cpu_clk);
        cpu_rd = 1'b0;
        d = cpu_do;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] v);
        cpu_ab = a;
        cpu_di = v;
        cpu_wr = 1'b1;
        @(negedge cpu_clk);
        cpu_wr = 1'b0;
    endtask

    task automatic ppu_read(input logic [13:0] a, output logic [7:0] d);
        ppu_ab = a;
        @(negedge cpu_clk);
        d = ppu_do;
    endtask

    task automatic ppu_write(input logic [13:0] a, input logic [7:0] v);
        ppu_ab = a;
        ppu_di = v;
        ppu_wr = 1'b1;
        @(negedge cpu_clk);
        ppu_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        prog = 1'b0; prog_we = 1'b0; prog_di = 8'h00;
        cpu_ab = 16'h0000; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_di = 8'h00;
        ppu_ab = 14'h0000; ppu_wr = 1'b0; ppu_di = 8'h00;
        #3 rst = 1'b0;
        #5;
        checks++;
        if ({load_done, load_err, mirror_v} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_flags got %b required 000", {load_done, load_err, mirror_v});
        end
        checks++;
        if ({mapper_id, cpu_do, ppu_do} !== 24'h0) begin
            errors++;
            $display("[TB] FAIL reset_data got %h required 000000", {mapper_id, cpu_do, ppu_do});
        end
        @(negedge cpu_clk);
        rst = 1'b1;
        @(negedge cpu_clk);
    endtask

    task automatic test_nrom();
        logic [7:0] d;
        start_load();
        send_header(8'h01, 8'h00, 8'h01, 8'h00);
        send_prg(0, 16384);
        finish_load("nrom");
        checks++;
        if ({load_err, mirror_v, mapper_id} !== 10'b01_0000_0000) begin
            errors++;
            $display("[TB] FAIL nrom_hdr got err=%b mv=%b map=%h required 0 1 00", load_err, mirror_v, mapper_id);
        end
        cpu_read(16'h8000, d); checks++;
        if (d !== 8'hA5) begin errors++; $display("[TB] FAIL nrom_8000 got %h required A5", d); end
        cpu_read(16'hC000, d); checks++;
        if (d !== 8'hA5) begin errors++; $display("[TB] FAIL nrom_c000_mirror got %h required A5", d); end
        cpu_read(16'hFFFC, d); checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL nrom_fffc got %h required 00", d); end
        cpu_read(16'hFFFD, d); checks++;
        if (d !== 8'hC0) begin errors++; $display("[TB] FAIL nrom_fffd got %h required C0", d); end
        cpu_read(16'hC123, d); checks++;
        if (d !== 8'h78) begin errors++; $display("[TB] FAIL nrom_c123 got %h required 78", d); end
        cpu_ab = 16'h8000;
        @(negedge cpu_clk); checks++;
        if (cpu_do !== 8'h78) begin errors++; $display("[TB] FAIL nrom_hold got %h required 78", cpu_do); end
        cpu_write(16'h8000, 8'h01);
        cpu_read(16'h8000, d); checks++;
        if (d !== 8'hA5) begin errors++; $display("[TB] FAIL nrom_write_ignored got %h required A5", d); end
        cpu_read(16'h4000, d); checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL nrom_unmapped got %h required 00", d); end
        cpu_write(16'h6010, 8'h3C);
        cpu_read(16'h6010, d); checks++;
        if (d !== 8'h3C) begin errors++; $display("[TB] FAIL prgram_rd got %h required 3C", d); end
        cpu_ab = 16'h6010; cpu_di = 8'h77; cpu_rd = 1'b1; cpu_wr = 1'b1;
        @(negedge cpu_clk);
        cpu_rd = 1'b0; cpu_wr = 1'b0; checks++;
        if (cpu_do !== 8'h3C) begin errors++; $display("[TB] FAIL prgram_rw_old got %h required 3C", cpu_do); end
        cpu_read(16'h6010, d); checks++;
        if (d !== 8'h77) begin errors++; $display("[TB] FAIL prgram_rw_new got %h required 77", d); end
        ppu_write(14'h0123, 8'h5A);
        ppu_read(14'h0123, d); checks++;
        if (d !== 8'h5A) begin errors++; $display("[TB] FAIL chrram_0123 got %h required 5A", d); end
        ppu_write(14'h1FFF, 8'hE7);
        ppu_read(14'h1FFF, d); checks++;
        if (d !== 8'hE7) begin errors++; $display("[TB] FAIL chrram_1fff got %h required E7", d); end
        ppu_read(14'h2000, d); checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL ppu_2000 got %h required 00", d); end
    endtask

    task automatic test_uxrom();
        logic [7:0] d;
        start_load();
        send_header(8'h02, 8'h00, 8'h24, 8'h00);
        for (int i = 0; i < 512; i++) send_byte(8'hEE);
        send_prg(2, 32768);
        finish_load("uxrom");
        checks++;
        if ({mirror_v, mapper_id} !== 9'h002) begin
            errors++;
            $display("[TB] FAIL uxrom_hdr got mv=%b map=%h required 0 02", mirror_v, mapper_id);
        end
        cpu_write(16'h8000, 8'h00);
        cpu_read(16'h8000, d); checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL uxrom_trainer_skipped got %h required 00", d); end
        cpu_read(16'h8001, d); checks++;
        if (d !== 8'h5B) begin errors++; $display("[TB] FAIL uxrom_b0_8001 got %h required 5B", d); end
        cpu_read(16'hC000, d); checks++;
        if (d !== 8'h01) begin errors++; $display("[TB] FAIL uxrom_fixed_c000 got %h required 01", d); end
        cpu_write(16'h8000, 8'h01);
        cpu_read(16'h8001, d); checks++;
        if (d !== 8'h1B) begin errors++; $display("[TB] FAIL uxrom_b1_8001 got %h required 1B", d); end
        cpu_write(16'h8000, 8'h03);
        cpu_read(16'h8000, d); checks++;
        if (d !== 8'h01) begin errors++; $display("[TB] FAIL uxrom_mask3 got %h required 01", d); end
        cpu_write(16'hA000, 8'h06);
        cpu_read(16'h8000, d); checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL uxrom_mask6 got %h required 00", d); end
        cpu_read(16'hC000, d); checks++;
        if (d !== 8'h01) begin errors++; $display("[TB] FAIL uxrom_fixed_after got %h required 01", d); end
    endtask

    task automatic test_bad_magic();
        start_load();
        send_byte(8'h4E); send_byte(8'h45);
        checks++;
        if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL magic_before got %b required 0", load_err); end
        send_byte(8'h54);
        prog_we = 1'b0;
        checks++;
        if ({load_err, load_done} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL magic_err got %b required 10", {load_err, load_done});
        end
        send_byte(8'h1A); send_byte(8'h01); send_byte(8'h00); send_byte(8'h30); send_byte(8'h00);
        for (int i = 0; i < 8; i++) send_byte(8'h00);
        prog_we = 1'b0;
        @(negedge cpu_clk); checks++;
        if ({load_err, mapper_id} !== 9'h102) begin
            errors++;
            $display("[TB] FAIL magic_ignored got err=%b map=%h required 1 02", load_err, mapper_id);
        end
    endtask

    task automatic test_bad_header();
        start_load();
        checks++;
        if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL restart_clears_err got %b required 0", load_err); end
        send_header(8'h03, 8'h00, 8'h00, 8'h00);
        prog_we = 1'b0;
        checks++;
        if ({load_err, load_done} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL prg3_err got %b required 10", {load_err, load_done});
        end
        start_load();
        send_header(8'h01, 8'h00, 8'h10, 8'h00);
        prog_we = 1'b0;
        checks++;
        if ({load_err, mapper_id} !== 9'h101) begin
            errors++;
            $display("[TB] FAIL mapper1_err got err=%b map=%h required 1 01", load_err, mapper_id);
        end
    endtask

    task automatic test_prog_drop();
        start_load();
        send_header(8'h01, 8'h00, 8'h00, 8'h00);
        send_prg(0, 100);
        prog_we = 1'b0;
        checks++;
        if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL drop_before got %b required 0", load_err); end
        prog = 1'b0;
        @(negedge cpu_clk); checks++;
        if ({load_err, load_done} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL drop_err got %b required 10", {load_err, load_done});
        end
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] d;
        start_load();
        send_header(8'h02, 8'h00, 8'h21, 8'h00);
        send_prg(2, 50);
        checks++;
        if ({mirror_v, mapper_id} !== 9'h102) begin
            errors++;
            $display("[TB] FAIL midload_hdr got mv=%b map=%h required 1 02", mirror_v, mapper_id);
        end
        #2;
        rst = 1'b0; prog = 1'b0; prog_we = 1'b0;
        #1; checks++;
        if ({load_done, load_err, mirror_v, mapper_id, cpu_do, ppu_do} !== 27'h0) begin
            errors++;
            $display("[TB] FAIL midload_reset got %h required 0000000",
                     {load_done, load_err, mirror_v, mapper_id, cpu_do, ppu_do});
        end
        @(negedge cpu_clk);
        rst = 1'b1;
        @(negedge cpu_clk);
        cpu_read(16'h8000, d); checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL post_reset_cpu got %h required 00", d); end
        ppu_read(14'h0000, d); checks++;
        if (d !== 8'h00) begin errors++; $display("[TB] FAIL post_reset_ppu got %h required 00", d); end
    endtask

    task automatic test_cnrom();
        logic [7:0] d;
        start_load();
        send_header(8'h01, 8'h02, 8'h30, 8'h00);
        send_prg(3, 16384);
        send_chr(16384);
        finish_load("cnrom");
        checks++;
        if ({mirror_v, mapper_id} !== 9'h003) begin
            errors++;
            $display("[TB] FAIL cnrom_hdr got mv=%b map=%h required 0 03", mirror_v, mapper_id);
        end
        ppu_read(14'h0000, d); checks++;
        if (d !== 8'h3C) begin errors++; $display("[TB] FAIL cnrom_b0_0000 got %h required 3C", d); end
        ppu_write(14'h0005, 8'hAA);
        ppu_read(14'h0005, d); checks++;
        if (d !== 8'h39) begin errors++; $display("[TB] FAIL cnrom_ppu_wr_ignored got %h required 39", d); end
        cpu_write(16'h9000, 8'h01);
        ppu_read(14'h0000, d); checks++;
        if (d !== 8'h1C) begin errors++; $display("[TB] FAIL cnrom_b1_0000 got %h required 1C", d); end
        ppu_read(14'h0005, d); checks++;
        if (d !== 8'h19) begin errors++; $display("[TB] FAIL cnrom_b1_0005 got %h required 19", d); end
        cpu_write(16'h9000, 8'h03);
        ppu_read(14'h0000, d); checks++;
        if (d !== 8'h1C) begin errors++; $display("[TB] FAIL cnrom_mask3 got %h required 1C", d); end
        cpu_write(16'h8000, 8'h02);
        ppu_read(14'h1FFF, d); checks++;
        if (d !== 8'hDC) begin errors++; $display("[TB] FAIL cnrom_mask2_1fff got %h required DC", d); end
        cpu_read(16'h8123, d); checks++;
        if (d !== 8'h78) begin errors++; $display("[TB] FAIL cnrom_prg_8123 got %h required 78", d); end
        cpu_read(16'hC123, d); checks++;
        if (d !== 8'h78) begin errors++; $display("[TB] FAIL cnrom_prg_c123 got %h required 78", d); end
    endtask

    initial begin
        test_reset();
        test_nrom();
        test_uxrom();
        test_bad_magic();
        test_bad_header();
        test_prog_drop();
        test_reset_mid_load();
        test_cnrom();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
